// File: rtl/rs_encode_ctrl.sv
// RS(15,13) systematic encoder controller over GF(16): forwards 13 message
// symbols through a one-entry output register, then appends 2 LFSR parity symbols.
module rs_encode_ctrl #(
  parameter int SYMBOL_WIDTH = 4,
  parameter int N            = 15,
  parameter int K            = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SYMBOL_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_parity,
  output logic                    out_last
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(K - 1);
  // Exponents of the generator coefficients g1 = alpha^4, g0 = alpha^1.
  localparam logic [3:0] G1_EXP = 4'd4;
  localparam logic [3:0] G0_EXP = 4'd1;

  typedef enum logic [1:0] {DATA, PAR1, PAR2} state_t;

  // Symbol encoding: bit3 is the alpha^0 coefficient; index = exponent + 1, 0 for zero.
  function automatic logic [3:0] index_lookup(input logic [3:0] sym);
    case (sym)
      4'b1000: return 4'd1;
      4'b0100: return 4'd2;
      4'b0010: return 4'd3;
      4'b0001: return 4'd4;
      4'b1100: return 4'd5;
      4'b0110: return 4'd6;
      4'b0011: return 4'd7;
      4'b1101: return 4'd8;
      4'b1010: return 4'd9;
      4'b0101: return 4'd10;
      4'b1110: return 4'd11;
      4'b0111: return 4'd12;
      4'b1111: return 4'd13;
      4'b1011: return 4'd14;
      4'b1001: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] symbol_lookup(input logic [3:0] idx);
    case (idx)
      4'd1:    return 4'b1000;
      4'd2:    return 4'b0100;
      4'd3:    return 4'b0010;
      4'd4:    return 4'b0001;
      4'd5:    return 4'b1100;
      4'd6:    return 4'b0110;
      4'd7:    return 4'b0011;
      4'd8:    return 4'b1101;
      4'd9:    return 4'b1010;
      4'd10:   return 4'b0101;
      4'd11:   return 4'b1110;
      4'd12:   return 4'b0111;
      4'd13:   return 4'b1111;
      4'd14:   return 4'b1011;
      4'd15:   return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] gf_mul_const(input logic [3:0] sym, input logic [3:0] exp_c);
    logic [3:0] idx;
    logic [4:0] e;
    idx = index_lookup(sym);
    if (idx == 4'd0) return 4'b0000;
    e = 5'(idx) - 5'd1 + 5'(exp_c);
    if (e >= 5'd15) e = e - 5'd15;
    return symbol_lookup(e[3:0] + 4'd1);
  endfunction

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [3:0]              r1_reg, r1_next;
  logic [3:0]              r0_reg, r0_next;
  logic                    out_valid_reg, out_valid_next;
  logic [SYMBOL_WIDTH-1:0] out_data_reg, out_data_next;
  logic                    out_parity_reg, out_parity_next;
  logic                    out_last_reg, out_last_next;
  logic                    slot_free;
  logic                    ready_comb;
  logic [3:0]              fb;

  assign slot_free = !out_valid_reg || out_ready;
  assign fb        = in_data ^ r1_reg;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    r1_next         = r1_reg;
    r0_next         = r0_reg;
    out_valid_next  = out_valid_reg && !out_ready;
    out_data_next   = out_data_reg;
    out_parity_next = out_parity_reg;
    out_last_next   = out_last_reg;
    ready_comb      = 1'b0;
    case (state_reg)
      DATA: begin
        ready_comb = slot_free;
        if (in_valid && slot_free) begin
          out_valid_next  = 1'b1;
          out_data_next   = in_data;
          out_parity_next = 1'b0;
          out_last_next   = 1'b0;
          r1_next         = r0_reg ^ gf_mul_const(fb, G1_EXP);
          r0_next         = gf_mul_const(fb, G0_EXP);
          if (cnt_reg == LAST_MSG) begin
            cnt_next   = '0;
            state_next = PAR1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      PAR1: begin
        if (slot_free) begin
          out_valid_next  = 1'b1;
          out_data_next   = r1_reg;
          out_parity_next = 1'b1;
          out_last_next   = 1'b0;
          state_next      = PAR2;
        end
      end
      PAR2: begin
        // Clearing the LFSR here keeps the next codeword independent of this one.
        if (slot_free) begin
          out_valid_next  = 1'b1;
          out_data_next   = r0_reg;
          out_parity_next = 1'b1;
          out_last_next   = 1'b1;
          r1_next         = 4'b0000;
          r0_next         = 4'b0000;
          state_next      = DATA;
        end
      end
      default: state_next = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= DATA;
      cnt_reg        <= '0;
      r1_reg         <= 4'b0000;
      r0_reg         <= 4'b0000;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_parity_reg <= 1'b0;
      out_last_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      r1_reg         <= r1_next;
      r0_reg         <= r0_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_parity_reg <= out_parity_next;
      out_last_reg   <= out_last_next;
    end
  end

  assign in_ready   = ready_comb && !reset;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_parity = out_parity_reg;
  assign out_last   = out_last_reg;

endmodule
